// File: rtl/lcd_ctrl_param.sv
// lcd_ctrl_param: IMG x IMG byte-loaded image buffer streamed out as a movable WIN x WIN window.
// Optional window mirroring (cmd 6/7) is built when LCD_CTRL_MIRROR_EN is defined.
module lcd_ctrl_param #(
   parameter int IMG = 6,
   parameter int WIN = 3,
   parameter int DW  = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] datain,
   input  logic [2:0]    cmd,
   input  logic          cmd_valid,
   output logic [DW-1:0] dataout,
   output logic          output_valid,
   output logic          busy
);
   localparam int NPIX = IMG * IMG;
   localparam int MAXO = IMG - WIN;
   localparam int OW   = MAXO > 0 ? $clog2(MAXO + 1) : 1;
   localparam int AW   = $clog2(NPIX);
   localparam int WW   = WIN > 1 ? $clog2(WIN) : 1;
   localparam logic [OW-1:0] ORG   = OW'((MAXO + 1) / 2);
   localparam logic [OW-1:0] OMAX  = OW'(MAXO);
   localparam logic [WW-1:0] WLAST = WW'(WIN - 1);
   localparam logic [AW-1:0] ALAST = AW'(NPIX - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_OUT} state_t;

   state_t          r_state, w_next;
   logic [2:0]      r_cmd;
   logic [OW-1:0]   r_row, r_col;
   logic [AW-1:0]   r_idx;
   logic [WW-1:0]   r_wr, r_wc;
   logic            r_done, r_ov;
   logic [DW-1:0]   r_dout;
   logic [DW-1:0]   r_buf [NPIX];
   logic            w_mx, w_my;
   logic [AW-1:0]   w_addr;

   always_ff @(posedge clk or negedge reset)
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (cmd_valid) w_next = (cmd == 3'd1) ? S_LOAD : S_CALC;
         S_LOAD:  if (r_idx == ALAST) w_next = S_CALC;
         S_CALC:  w_next = S_OUT;
         default: if (r_done) w_next = S_IDLE;
      endcase
   end

   // Mirroring reflects the beat position inside the window, not the origin.
   assign w_addr = AW'((int'(r_row) + (w_my ? WIN - 1 - int'(r_wr) : int'(r_wr))) * IMG
                     + int'(r_col) + (w_mx ? WIN - 1 - int'(r_wc) : int'(r_wc)));

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_cmd  <= '0;
         r_row  <= ORG;
         r_col  <= ORG;
         r_idx  <= '0;
         r_wr   <= '0;
         r_wc   <= '0;
         r_done <= 1'b0;
         r_ov   <= 1'b0;
         r_dout <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (cmd_valid) begin
               r_cmd <= cmd;
               r_idx <= '0;
            end
            S_LOAD: r_idx <= r_idx + 1'b1;
            S_CALC: begin
               r_wr   <= '0;
               r_wc   <= '0;
               r_done <= 1'b0;
               case (r_cmd)
                  3'd1: begin
                     r_row <= ORG;
                     r_col <= ORG;
                  end
                  3'd2: if (r_col != OMAX) r_col <= r_col + 1'b1;
                  3'd3: if (r_col != '0) r_col <= r_col - 1'b1;
                  3'd4: if (r_row != '0) r_row <= r_row - 1'b1;
                  3'd5: if (r_row != OMAX) r_row <= r_row + 1'b1;
                  default: ;
               endcase
            end
            default: if (r_done) r_ov <= 1'b0;
            else begin
               r_ov   <= 1'b1;
               r_dout <= r_buf[w_addr];
               r_wc   <= (r_wc == WLAST) ? '0 : r_wc + 1'b1;
               if (r_wc == WLAST) begin
                  if (r_wr == WLAST) r_done <= 1'b1;
                  else               r_wr   <= r_wr + 1'b1;
               end
            end
         endcase
      end

   // Image storage is deliberately not reset; an aborted load leaves old pixels in place.
   always_ff @(posedge clk)
      if (r_state == S_LOAD) r_buf[r_idx] <= datain;

`ifdef LCD_CTRL_MIRROR_EN
   logic r_mx, r_my;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_mx <= 1'b0;
         r_my <= 1'b0;
      end else if (r_state == S_CALC) begin
         r_mx <= (r_cmd != 3'd1) && (r_mx ^ (r_cmd == 3'd6));
         r_my <= (r_cmd != 3'd1) && (r_my ^ (r_cmd == 3'd7));
      end

   assign w_mx = r_mx;
   assign w_my = r_my;
`else
   assign w_mx = 1'b0;
   assign w_my = 1'b0;
`endif

   assign dataout      = r_dout;
   assign output_valid = r_ov;
   assign busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_lcd_ctrl_param.sv
// tb_lcd_ctrl_param: directed bench for lcd_ctrl_param (IMG=6, WIN=3, DW=8).
// Mirror expectations follow LCD_CTRL_MIRROR_EN when defined.
module tb_lcd_ctrl_param;
   localparam int IMG = 6;
   localparam int WIN = 3;
   localparam int DW  = 8;

   typedef int arr9_t [9];

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] datain = '0;
   logic [2:0]    cmd = '0;
   logic          cmd_valid = 1'b0;
   logic [DW-1:0] dataout;
   logic          output_valid;
   logic          busy;

   int    n_chk = 0;
   int    n_fail = 0;
   int    beats [16];
   int    nb, bcyc, first, dout_after;
   logic  hold = 1'b0;
   arr9_t base_win = '{14, 15, 16, 20, 21, 22, 26, 27, 28};

   always #5 clk = ~clk;

   lcd_ctrl_param #(.IMG(IMG), .WIN(WIN), .DW(DW)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .datain       (datain),
      .cmd          (cmd),
      .cmd_valid    (cmd_valid),
      .dataout      (dataout),
      .output_valid (output_valid),
      .busy         (busy)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Issues one command and records every post-edge sample until busy drops.
   task automatic run(input logic [2:0] c, input int base);
      int t;
      @(negedge clk);
      cmd = c;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      nb = 0;
      bcyc = 0;
      first = -1;
      for (t = 0; t < 300; t++) begin
         if (busy) bcyc++;
         if (output_valid) begin
            if (first < 0) first = t;
            if (nb < 16) beats[nb] = int'(dataout);
            nb++;
         end
         if (!busy) break;
         @(negedge clk);
         cmd_valid = hold;
         cmd = 3'd2;
         datain = DW'(base + t);
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      dout_after = int'(dataout);
      check("terminate", int'(t < 300), 1);
   endtask

   task automatic step(input string tag, input logic [2:0] c, input int base, input arr9_t e);
      run(c, base);
      check({tag, " beats"}, nb, 9);
      for (int i = 0; i < 9; i++) check($sformatf("%s[%0d]", tag, i), beats[i], e[i]);
      check({tag, " latency"}, first, c == 3'd1 ? IMG * IMG + 2 : 2);
      check({tag, " busy"}, bcyc, c == 3'd1 ? IMG * IMG + WIN * WIN + 2 : WIN * WIN + 2);
      check({tag, " hold"}, dout_after, e[8]);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst busy", int'(busy), 0);
      check("rst valid", int'(output_valid), 0);
      check("rst dout", int'(dataout), 0);
      @(negedge clk);
      reset = 1'b1;

      step("load0", 3'd1, 0, base_win);
      step("right1", 3'd2, 0, '{15, 16, 17, 21, 22, 23, 27, 28, 29});
      step("right2", 3'd2, 0, '{15, 16, 17, 21, 22, 23, 27, 28, 29});

      step("load1", 3'd1, 0, base_win);
      step("up1", 3'd4, 0, '{8, 9, 10, 14, 15, 16, 20, 21, 22});
      step("up2", 3'd4, 0, '{2, 3, 4, 8, 9, 10, 14, 15, 16});
      step("up3", 3'd4, 0, '{2, 3, 4, 8, 9, 10, 14, 15, 16});

      step("load2", 3'd1, 0, base_win);
      step("left1", 3'd3, 0, '{13, 14, 15, 19, 20, 21, 25, 26, 27});
      step("left2", 3'd3, 0, '{12, 13, 14, 18, 19, 20, 24, 25, 26});
      step("left3", 3'd3, 0, '{12, 13, 14, 18, 19, 20, 24, 25, 26});
      step("down1", 3'd5, 0, '{18, 19, 20, 24, 25, 26, 30, 31, 32});
      step("down2", 3'd5, 0, '{18, 19, 20, 24, 25, 26, 30, 31, 32});

      step("load3", 3'd1, 0, base_win);
      hold = 1'b1;
      step("busy_ign", 3'd0, 0, base_win);
      hold = 1'b0;
      step("refresh", 3'd0, 0, base_win);

      step("load4", 3'd1, 0, base_win);
`ifdef LCD_CTRL_MIRROR_EN
      step("mir_x", 3'd6, 0, '{16, 15, 14, 22, 21, 20, 28, 27, 26});
      step("mir_xy", 3'd7, 0, '{28, 27, 26, 22, 21, 20, 16, 15, 14});
      step("load_clr", 3'd1, 0, base_win);
`else
      step("cmd6", 3'd6, 0, base_win);
      step("cmd7", 3'd7, 0, base_win);
`endif

      @(negedge clk);
      cmd = 3'd1;
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         datain = DW'(200 + i);
         @(posedge clk);
         @(negedge clk);
      end
      check("mid busy", int'(busy), 1);
      #2;
      reset = 1'b0;
      #1;
      check("abort busy", int'(busy), 0);
      check("abort valid", int'(output_valid), 0);
      check("abort dout", int'(dataout), 0);
      @(negedge clk);
      reset = 1'b1;
      step("reload", 3'd1, 100, '{114, 115, 116, 120, 121, 122, 126, 127, 128});
      step("refresh2", 3'd0, 0, '{114, 115, 116, 120, 121, 122, 126, 127, 128});

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
